// File: rtl/stream_mem_arbiter_if.sv
// Bus bundle for stream_mem_arbiter: per-port request/response streams plus the memory side.
// master = arbiter view, slave = environment view (requesters and memory).
interface stream_mem_arbiter_if #(
    parameter int unsigned NumPorts   = 2,
    parameter type         mem_req_t  = logic,
    parameter type         mem_resp_t = logic
);
    mem_req_t                req_i [NumPorts];
    logic     [NumPorts-1:0] req_valid_i;
    logic     [NumPorts-1:0] req_ready_o;

    mem_resp_t               resp_o;
    logic     [NumPorts-1:0] resp_valid_o;
    logic     [NumPorts-1:0] resp_ready_i;

    mem_req_t                mem_req_o;
    logic                    mem_req_valid_o;
    logic                    mem_req_ready_i;

    mem_resp_t               mem_resp_i;
    logic                    mem_resp_valid_i;

    modport master (
        input  req_i, req_valid_i, resp_ready_i, mem_req_ready_i, mem_resp_i, mem_resp_valid_i,
        output req_ready_o, resp_o, resp_valid_o, mem_req_o, mem_req_valid_o
    );

    modport slave (
        output req_i, req_valid_i, resp_ready_i, mem_req_ready_i, mem_resp_i, mem_resp_valid_i,
        input  req_ready_o, resp_o, resp_valid_o, mem_req_o, mem_req_valid_o
    );
endinterface

// File: rtl/stream_mem_arbiter.sv
// Credit-limited N:1 memory request arbiter with in-order response routing back to the issuing port.
// Define STREAM_MEM_ARBITER_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module stream_mem_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    stream_mem_arbiter_if.master        bus,
    output logic                        idle_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned SelW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    if (MaxOutstanding < 1) begin : g_bad_max
        $error("MaxOutstanding must be at least 1");
    end

    logic [CntW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic            lock_q, lock_d;
    logic [SelW-1:0] sel, sel_q, pick, cand, head_idx;
    logic [PtrW-1:0] iwr_q, ird_q, rwr_q, rrd_q;
    logic [SelW-1:0] idx_mem_q  [MaxOutstanding];
    mem_resp_t       resp_mem_q [MaxOutstanding];
    logic            found, resp_pending, deliver, credit_ok, issue, push_r, pop_r;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef STREAM_MEM_ARBITER_RR_EN
    logic [SelW-1:0] rr_q;

    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = SelW'((32'(rr_q) + i) % NumPorts);
            if (!found && bus.req_valid_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (issue) begin
            rr_q <= (sel == SelW'(NumPorts - 1)) ? '0 : sel + 1'b1;
        end
    end
`else
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = NumPorts; i > 0; i--) begin
            cand = SelW'(i - 1);
            if (bus.req_valid_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end
`endif

    // A stalled request keeps its port until the memory accepts it.
    assign sel      = lock_q ? sel_q : pick;
    assign head_idx = idx_mem_q[ird_q];

    // Response FIFO falls through when empty; nothing is routed without a matching issue.
    assign resp_pending = (cnt_q != '0) && ((rcnt_q != '0) || bus.mem_resp_valid_i);
    assign bus.resp_o   = (rcnt_q != '0) ? resp_mem_q[rrd_q] : bus.mem_resp_i;
    assign deliver      = resp_pending && bus.resp_ready_i[head_idx];

    assign credit_ok           = (cnt_q < CntW'(MaxOutstanding)) || deliver;
    assign bus.mem_req_valid_o = rst_ni && ((credit_ok && (|bus.req_valid_i)) || lock_q);
    assign bus.mem_req_o       = bus.req_i[sel];
    assign issue               = bus.mem_req_valid_o && bus.mem_req_ready_i;

    always_comb begin
        bus.req_ready_o  = '0;
        bus.resp_valid_o = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            bus.req_ready_o[i]  = issue && (sel == SelW'(i));
            bus.resp_valid_o[i] = resp_pending && (head_idx == SelW'(i));
        end
    end

    assign push_r = bus.mem_resp_valid_i && (cnt_q != '0) && !((rcnt_q == '0) && deliver);
    assign pop_r  = deliver && (rcnt_q != '0);
    assign cnt_d  = cnt_q + CntW'(issue) - CntW'(deliver);
    assign rcnt_d = rcnt_q + CntW'(push_r) - CntW'(pop_r);
    assign lock_d = bus.mem_req_valid_o && !bus.mem_req_ready_i;
    assign idle_o = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            rcnt_q <= '0;
            lock_q <= 1'b0;
            sel_q  <= '0;
            iwr_q  <= '0;
            ird_q  <= '0;
            rwr_q  <= '0;
            rrd_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rcnt_q <= rcnt_d;
            lock_q <= lock_d;
            sel_q  <= sel;
            if (issue)   iwr_q <= ptr_inc(iwr_q);
            if (deliver) ird_q <= ptr_inc(ird_q);
            if (push_r)  rwr_q <= ptr_inc(rwr_q);
            if (pop_r)   rrd_q <= ptr_inc(rrd_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue)  idx_mem_q[iwr_q]  <= sel;
        if (push_r) resp_mem_q[rwr_q] <= bus.mem_resp_i;
    end

`ifndef SYNTHESIS
    mem_req_t req_hold_q;

    always_ff @(posedge clk_i) begin
        req_hold_q <= bus.mem_req_o;
        if (rst_ni) begin
            assert (!(bus.mem_resp_valid_i && (cnt_q == '0)))
                else $error("spurious memory response with nothing outstanding");
            assert (!(bus.mem_resp_valid_i && (rcnt_q == CntW'(MaxOutstanding))))
                else $error("memory response lost, response FIFO full");
            if (lock_q) begin
                assert (bus.mem_req_o == req_hold_q)
                    else $error("request payload changed while stalled");
            end
        end
    end
`endif
endmodule
